clint_irq_ctrl: RTL and testbench

CLINT_IRQ_CTRL -- requirements
Module: clint_irq_ctrl

---
 rtl/clint_irq_ctrl.sv | 101 ++++++++++
 tb/tb_clint_irq_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/clint_irq_ctrl.sv
// Machine-level interrupt front end: registers CLINT/external interrupt levels,
// arbitrates MEI > MSI > MTI and offers one trap at a time to the CPU.
module clint_irq_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mtip,
  input  logic             msip,
  input  logic             meip,
  input  logic             mstatus_mie,
  input  logic [2:0]       mie,
  output logic [2:0]       mip,
  output logic             irq_valid,
  output logic [3:0]       irq_cause,
  input  logic             irq_ready,
  output logic [CNT_W-1:0] irq_cnt
);
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] REQ      = 2'd1;
  localparam logic [1:0] WAIT_CLR = 2'd2;

  logic [SYNC_STAGES-1:0] meip_sync;
  logic [1:0]             tm_sw_q;
  logic [1:0]             state;
  logic [2:0]             sel;       // one-hot of latched source, mip bit order
  logic [2:0]             pend;
  logic [2:0]             win;
  logic [3:0]             win_cause;
  logic                   sel_pend;

  always_ff @(posedge clk) begin
    if (rst) begin
      meip_sync <= '0;
      tm_sw_q   <= '0;
    end else begin
      meip_sync <= {meip_sync[SYNC_STAGES-2:0], meip};
      tm_sw_q   <= {mtip, msip};
    end
  end

  assign mip      = {meip_sync[SYNC_STAGES-1], tm_sw_q};
  assign pend     = mstatus_mie ? (mip & mie) : 3'b000;
  assign sel_pend = |(pend & sel);

  always_comb begin
    win       = 3'b000;
    win_cause = 4'd0;
    if (pend[2]) begin
      win       = 3'b100;
      win_cause = 4'd11;
    end else if (pend[0]) begin
      win       = 3'b001;
      win_cause = 4'd3;
    end else if (pend[1]) begin
      win       = 3'b010;
      win_cause = 4'd7;
    end
  end

  // Cause is latched once per request; later arrivals wait for the next round.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sel       <= 3'b000;
      irq_valid <= 1'b0;
      irq_cause <= 4'd0;
      irq_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pend != 3'b000) begin
            state     <= REQ;
            sel       <= win;
            irq_cause <= win_cause;
            irq_valid <= 1'b1;
          end
        end
        REQ: begin
          if (irq_ready) begin
            state     <= WAIT_CLR;
            irq_valid <= 1'b0;
            if (irq_cnt != {CNT_W{1'b1}}) irq_cnt <= irq_cnt + CNT_W'(1);
          end else if (!sel_pend) begin
            state     <= IDLE;
            irq_valid <= 1'b0;
          end
        end
        WAIT_CLR: begin
          // Serviced source must drop (or interrupts be masked) before re-arming.
          if (!mstatus_mie || !sel_pend) state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          irq_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_clint_irq_ctrl.sv
// Directed and randomized checks of clint_irq_ctrl against a cycle-level model.
module tb_clint_irq_ctrl;
  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        rst, mtip, msip, meip, mstatus_mie, irq_ready;
  logic [2:0]  mie, mip, mip2;
  logic        irq_valid, irq_valid2;
  logic [3:0]  irq_cause, irq_cause2;
  logic [15:0] irq_cnt;
  logic [1:0]  irq_cnt2;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  clint_irq_ctrl #(.SYNC_STAGES(SYNC), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .mtip(mtip), .msip(msip), .meip(meip),
    .mstatus_mie(mstatus_mie), .mie(mie), .mip(mip), .irq_valid(irq_valid),
    .irq_cause(irq_cause), .irq_ready(irq_ready), .irq_cnt(irq_cnt));

  clint_irq_ctrl #(.SYNC_STAGES(SYNC), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .mtip(mtip), .msip(msip), .meip(meip),
    .mstatus_mie(mstatus_mie), .mie(mie), .mip(mip2), .irq_valid(irq_valid2),
    .irq_cause(irq_cause2), .irq_ready(irq_ready), .irq_cnt(irq_cnt2));

  // Reference: phase 0 = nothing offered, 1 = trap offered, 2 = serviced, awaiting clear
  bit [2:0] m_mip;
  int       m_phase, m_cause, m_cnt;
  bit       m_q[$];

  function automatic int src_bit(input int c);
    return (c == 11) ? 2 : (c == 3) ? 0 : 1;
  endfunction

  task automatic model_edge();
    bit [2:0] p;
    p = mstatus_mie ? (m_mip & mie) : 3'b000;
    if (rst) begin
      m_phase = 0; m_cause = 0; m_cnt = 0; m_mip = 3'b000;
      m_q = {};
      repeat (SYNC - 1) m_q.push_back(1'b0);
      return;
    end
    case (m_phase)
      0: if (p != 0) begin
           m_cause = p[2] ? 11 : p[0] ? 3 : 7;
           m_phase = 1;
         end
      1: if (irq_ready) begin
           m_cnt++;
           m_phase = 2;
         end else if (!p[src_bit(m_cause)]) m_phase = 0;
      2: if (!mstatus_mie || !p[src_bit(m_cause)]) m_phase = 0;
      default: m_phase = 0;
    endcase
    m_q.push_back(meip);
    m_mip = {m_q.pop_front(), mtip, msip};
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic compare();
    chk("mip", {29'd0, mip}, {29'd0, m_mip});
    chk("valid", {31'd0, irq_valid}, (m_phase == 1) ? 1 : 0);
    chk("cause", {28'd0, irq_cause}, m_cause);
    chk("cnt", {16'd0, irq_cnt}, (m_cnt > 65535) ? 65535 : m_cnt);
    chk("cnt_w2", {30'd0, irq_cnt2}, (m_cnt > 3) ? 3 : m_cnt);
    chk("valid_w2", {31'd0, irq_valid2}, (m_phase == 1) ? 1 : 0);
    chk("cause_w2", {28'd0, irq_cause2}, m_cause);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 10 && irq_valid !== 1'b1; i++) cyc();
    chk(tag, {31'd0, irq_valid}, 1);
  endtask

  task automatic accept();
    irq_ready = 1'b1;
    cyc();
    irq_ready = 1'b0;
  endtask

  initial begin
    int nv, rises;
    logic prev;
    rst = 1'b1; mtip = 0; msip = 0; meip = 0; mstatus_mie = 0; irq_ready = 0; mie = 3'b000;
    m_mip = 0; m_phase = 0; m_cause = 0; m_cnt = 0;
    repeat (SYNC - 1) m_q.push_back(1'b0);
    repeat (3) cyc();
    chk("rst_valid", {31'd0, irq_valid}, 0);
    chk("rst_cnt", {16'd0, irq_cnt}, 0);
    rst = 1'b0;
    cyc();

    // Timer: two-cycle latency, acceptance clears valid and counts.
    mie = 3'b010; mstatus_mie = 1'b1; mtip = 1'b1;
    cyc();
    chk("tmr_mip", {29'd0, mip}, 3'b010);
    chk("tmr_lat1", {31'd0, irq_valid}, 0);
    cyc();
    chk("tmr_valid", {31'd0, irq_valid}, 1);
    chk("tmr_cause", {28'd0, irq_cause}, 7);
    repeat (2) cyc();
    accept();
    chk("tmr_acc_valid", {31'd0, irq_valid}, 0);
    chk("tmr_cnt", {16'd0, irq_cnt}, 1);
    mtip = 1'b0;
    repeat (3) cyc();

    // Priority: MSI latched first, late MEI must not displace it.
    mie = 3'b111; msip = 1'b1; mtip = 1'b1;
    cyc();
    meip = 1'b1;
    cyc();
    chk("pri_cause", {28'd0, irq_cause}, 3);
    repeat (2) cyc();
    chk("pri_mip", {29'd0, mip}, 3'b111);
    chk("pri_hold", {28'd0, irq_cause}, 3);
    accept();
    chk("pri_cnt", {16'd0, irq_cnt}, 2);
    mstatus_mie = 1'b0;
    cyc();
    chk("pri_masked", {31'd0, irq_valid}, 0);
    mstatus_mie = 1'b1;
    cyc();
    chk("pri_mei_valid", {31'd0, irq_valid}, 1);
    chk("pri_mei_cause", {28'd0, irq_cause}, 11);
    accept();
    msip = 0; mtip = 0; meip = 0;
    repeat (4) cyc();

    // Withdrawal, then ready together with the drop.
    mie = 3'b001; msip = 1'b1;
    wait_valid("wd_req");
    msip = 1'b0;
    cyc();
    chk("wd_hold", {31'd0, irq_valid}, 1);
    cyc();
    chk("wd_drop", {31'd0, irq_valid}, 0);
    chk("wd_cnt", {16'd0, irq_cnt}, 3);
    msip = 1'b1;
    wait_valid("wd_req2");
    irq_ready = 1'b1; msip = 1'b0;
    cyc();
    irq_ready = 1'b0;
    chk("wd_race_cnt", {16'd0, irq_cnt}, 4);
    repeat (2) cyc();

    // No duplicate while the serviced source stays high.
    mie = 3'b010; mtip = 1'b1;
    wait_valid("nd_req");
    accept();
    nv = 0;
    repeat (50) begin cyc(); nv += int'(irq_valid); end
    chk("nd_quiet", nv, 0);
    mtip = 1'b0;
    cyc();
    mtip = 1'b1;
    rises = 0; prev = 1'b0;
    repeat (10) begin
      cyc();
      if (irq_valid && !prev) rises++;
      prev = irq_valid;
    end
    chk("nd_one_new", rises, 1);
    accept();
    chk("nd_cnt", {16'd0, irq_cnt}, 6);
    chk("sat_w2_a", {30'd0, irq_cnt2}, 3);
    mtip = 1'b0;
    repeat (3) cyc();

    // Reset wins over a same-cycle acceptance.
    mie = 3'b001; msip = 1'b1;
    wait_valid("rr_req");
    rst = 1'b1; irq_ready = 1'b1;
    cyc();
    chk("rr_valid", {31'd0, irq_valid}, 0);
    chk("rr_cnt", {16'd0, irq_cnt}, 0);
    chk("rr_cause", {28'd0, irq_cause}, 0);
    rst = 1'b0; irq_ready = 1'b0; msip = 1'b0;
    repeat (3) cyc();

    // Saturation of the narrow counter.
    for (int k = 0; k < 5; k++) begin
      msip = 1'b1;
      wait_valid("sat_req");
      accept();
      msip = 1'b0;
      repeat (2) cyc();
    end
    chk("sat_cnt16", {16'd0, irq_cnt}, 5);
    chk("sat_cnt2", {30'd0, irq_cnt2}, 3);

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      rst         = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 15) == 0) mie = 3'($urandom);
      mstatus_mie = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 3) == 0) mtip = ~mtip;
      if ($urandom_range(0, 3) == 0) msip = ~msip;
      if ($urandom_range(0, 5) == 0) meip = ~meip;
      irq_ready   = ($urandom_range(0, 2) == 0);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
